// File: rtl/eda_compare_kxk.sv
// ---------------------------------------------------------------------------
// eda_compare_kxk
// Regional-extremum compare stage for a KxK window. It takes one window per
// handshake and finds the max (or min) over the centre and its connected,
// in-bounds neighbours. It flags whether the centre is a regional candidate
// and registers the neighbours that tie with the extremum. The tied neighbours
// that have not been visited yet are then pushed downstream one per handshake,
// in ascending bit order.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   flush              synchronous abort; takes priority over everything else
//   win_valid/ready    window handshake
//   window_values      WINDOW_WIDTH pixels in raster order; centre is the middle pixel
//   neigh_addr_valid   neighbour lies inside the image
//   iterated_idx       neighbour has already been visited
//   res_valid          one-cycle strobe when a new result is registered
//   compare_out        the centre is a regional candidate
//   equal_positions    connected, valid neighbours that equal the extremum
//   push_valid/ready   push handshake toward the neighbour FIFO
//   push_idx           neighbour bit index being pushed
//   push_onehot        one-hot form of push_idx
//   busy               block is not idle
// Neighbour bit b maps to window index b when b < centre, else b+1.
// ---------------------------------------------------------------------------
module eda_compare_kxk #(
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned WIN_K        = 3,
    parameter int unsigned WINDOW_WIDTH = WIN_K * WIN_K,
    parameter int unsigned NB           = WINDOW_WIDTH - 1,
    parameter int unsigned CONN         = 8,
    parameter int unsigned MODE_MIN     = 0,
    parameter int unsigned IDX_W        = $clog2(NB)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush,
    input  logic                                win_valid,
    output logic                                win_ready,
    input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
    input  logic [NB-1:0]                       neigh_addr_valid,
    input  logic [NB-1:0]                       iterated_idx,
    output logic                                res_valid,
    output logic                                compare_out,
    output logic [NB-1:0]                       equal_positions,
    output logic                                push_valid,
    input  logic                                push_ready,
    output logic [IDX_W-1:0]                    push_idx,
    output logic [NB-1:0]                       push_onehot,
    output logic                                busy
);

    localparam int unsigned C  = (WINDOW_WIDTH - 1) / 2;
    localparam int unsigned CR = (WIN_K - 1) / 2;

    if (WIN_K < 3 || (WIN_K % 2) == 0) begin : g_bad_k
        $error("eda_compare_kxk: WIN_K must be odd and >= 3");
    end

    typedef enum logic [1:0] {IDLE, CALC, DRAIN} state_t;

    state_t                                state;
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0]   win_q;
    logic [NB-1:0]                         nav_q;
    logic [NB-1:0]                         iter_q;
    logic [NB-1:0]                         pending;

    logic [NB-1:0]                         conn_mask;
    logic [PIXEL_WIDTH-1:0]                nb_px [NB];
    logic [PIXEL_WIDTH-1:0]                centre_px;

    logic [NB-1:0]                         act_c;
    logic [PIXEL_WIDTH-1:0]                ext_c;
    logic [NB-1:0]                         eq_c;
    logic [NB-1:0]                         equal_c;
    logic                                  cmp_c;
    logic [NB-1:0]                         calc_pend_c;
    logic [NB-1:0]                         drain_rest_c;
    logic [IDX_W-1:0]                      first_c;
    logic [IDX_W-1:0]                      next_c;

    // Lowest set bit of a neighbour mask (0 when empty).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NB-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(NB) - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Per-neighbour pixel slice and connectivity; all elaboration-time constants.
    for (genvar b = 0; b < NB; b++) begin : g_nb
        localparam int unsigned BU  = b;
        localparam int unsigned W   = (BU < C) ? BU : BU + 1;
        localparam int unsigned ROW = W / WIN_K;
        localparam int unsigned COL = W % WIN_K;
        assign nb_px[b]     = win_q[W*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign conn_mask[b] = (CONN == 4) ? ((ROW == CR) || (COL == CR)) : 1'b1;
    end

    assign centre_px = win_q[C*PIXEL_WIDTH +: PIXEL_WIDTH];

    // Extremum over the centre and active neighbours, plus tie mask.
    always_comb begin
        act_c = nav_q & conn_mask;
        ext_c = centre_px;
        eq_c  = '0;
        for (int b = 0; b < int'(NB); b++) begin
            if (act_c[b]) begin
                if (MODE_MIN != 0) begin
                    if (nb_px[b] < ext_c) ext_c = nb_px[b];
                end else begin
                    if (nb_px[b] > ext_c) ext_c = nb_px[b];
                end
            end
        end
        for (int b = 0; b < int'(NB); b++) begin
            eq_c[b] = (nb_px[b] == ext_c);
        end
        equal_c      = eq_c & act_c;
        cmp_c        = (ext_c == centre_px);
        calc_pend_c  = equal_c & ~iter_q;
        drain_rest_c = pending & ~push_onehot;
        first_c      = lowest_idx(calc_pend_c);
        next_c       = lowest_idx(drain_rest_c);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            pending         <= '0;
            win_q           <= '0;
            nav_q           <= '0;
            iter_q          <= '0;
            win_ready       <= 1'b1;
            res_valid       <= 1'b0;
            compare_out     <= 1'b0;
            equal_positions <= '0;
            push_valid      <= 1'b0;
            push_idx        <= '0;
            push_onehot     <= '0;
            busy            <= 1'b0;
        end else if (flush) begin
            state           <= IDLE;
            pending         <= '0;
            win_ready       <= 1'b1;
            res_valid       <= 1'b0;
            compare_out     <= 1'b0;
            equal_positions <= '0;
            push_valid      <= 1'b0;
            push_idx        <= '0;
            push_onehot     <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    res_valid <= 1'b0;
                    if (win_valid && win_ready) begin
                        win_q     <= window_values;
                        nav_q     <= neigh_addr_valid;
                        iter_q    <= iterated_idx;
                        state     <= CALC;
                        win_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                CALC: begin
                    res_valid       <= 1'b1;
                    compare_out     <= cmp_c;
                    equal_positions <= equal_c;
                    pending         <= calc_pend_c;
                    if (calc_pend_c != '0) begin
                        state       <= DRAIN;
                        push_valid  <= 1'b1;
                        push_idx    <= first_c;
                        push_onehot <= NB'(1) << first_c;
                    end else begin
                        state     <= IDLE;
                        win_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DRAIN: begin
                    res_valid <= 1'b0;
                    if (push_ready) begin
                        pending <= drain_rest_c;
                        if (drain_rest_c == '0) begin
                            state       <= IDLE;
                            push_valid  <= 1'b0;
                            push_idx    <= '0;
                            push_onehot <= '0;
                            win_ready   <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            push_idx    <= next_c;
                            push_onehot <= NB'(1) << next_c;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/eda_compare_kxk.md
Name: eda_compare_kxk

Overview:
- Parametrised successor of the 3x3 regional-extremum compare stage in the imregionalmax datapath.
- Accepts one KxK window per handshake and computes the extremum over the centre plus its connected, in-bounds neighbours. Extremum is max or min by mode; connectivity is 4 or 8.
- Flags whether the centre is a regional candidate and registers the equal-neighbour mask.
- Serialises the push positions one at a time to the downstream neighbour FIFO under valid/ready.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- WIN_K, 3, window side; must be odd and >= 3.
- WINDOW_WIDTH, WIN_K*WIN_K, derived; pixels per window.
- NB, WINDOW_WIDTH-1, derived; neighbour count.
- CONN, 8, 8 = all neighbours; 4 = only same row or same column as centre.
- MODE_MIN, 0, 0 = regional max; 1 = regional min.
- IDX_W, $clog2(NB), derived; push index width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort, highest priority.
- win_valid  in  1  window offered.
- win_ready  out  1  block can accept a window.
- window_values  in  PIXEL_WIDTH*WINDOW_WIDTH  pixel i at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH]; raster order; centre C=(WINDOW_WIDTH-1)/2.
- neigh_addr_valid  in  NB  neighbour inside image.
- iterated_idx  in  NB  neighbour already visited.
- res_valid  out  1  one-cycle result strobe.
- compare_out  out  1  centre is a candidate.
- equal_positions  out  NB  connected valid neighbours equal to the extremum.
- push_valid  out  1  push position offered.
- push_ready  in  1  FIFO accepts the push.
- push_idx  out  IDX_W  neighbour bit index being pushed.
- push_onehot  out  NB  one-hot of push_idx.
- busy  out  1  state != IDLE.

Behaviour:
- Neighbour bit mapping: window index i<C maps to bit i; i>C maps to bit i-1.
- conn_mask: all ones for CONN=8. For CONN=4, a bit is set iff its window position shares the centre row or centre column.
- Reset (async) and flush (sync) both force:
  - state=IDLE; pending=0;
  - res_valid=0, compare_out=0, equal_positions=0, push_valid=0, push_idx=0, push_onehot=0, busy=0;
  - win_ready=1 after the event.
  - A handshake in the same cycle as flush is dropped.
- States: IDLE, CALC, DRAIN.
- IDLE:
  - win_ready=1.
  - On win_valid&win_ready, register window_values, neigh_addr_valid and iterated_idx, then go to CALC.
- CALC, one cycle, win_ready=0:
  - act = neigh_addr_valid & conn_mask.
  - ext = max (or min if MODE_MIN) over the centre and all neighbours with act set; excluded neighbours never affect the result.
  - Registered at the CALC exit edge:
    - compare_out = (ext == centre), i.e. no active neighbour strictly beyond the centre; ties give 1.
    - equal_positions = eq_mask & act.
    - pending = equal_positions & ~iterated_idx.
  - Go to DRAIN if pending != 0, else go to IDLE.
- res_valid is high for exactly the first cycle after CALC.
  - compare_out and equal_positions hold until the next CALC exit, flush or reset.
- DRAIN:
  - push_valid=1; push_idx = lowest set bit of pending; push_onehot = 1<<push_idx.
  - On push_ready, clear that bit. If it was the last bit, go to IDLE next cycle with push_valid=0.
  - With push_ready=0, push_valid, push_idx and push_onehot stay stable.
  - Ordering is strictly ascending bit index.
- Latency: accept at edge T; res_valid and the first push_valid appear in cycle T+2.
- Throughput:
  - No pushes: one window every 2 cycles (win_ready high in the res_valid cycle).
  - Otherwise: 2 + number of pushes cycles per window, assuming push_ready is always high.
- Arithmetic is unsigned, PIXEL_WIDTH wide; no widening.
- All neighbours inactive: ext = centre, compare_out=1, equal=0, no DRAIN.

Test Plan:
- K=3, CONN=8, max; all pixels 0x10; valid=0xFF; iterated=0; push_ready=1 -> res_valid at T+2, compare_out=1, equal=0xFF; push_idx 0..7 on 8 consecutive cycles; then win_ready=1.
- Centre 0x20, window index 2 = 0x30, others 0x10 -> compare_out=0, equal=0x04, single push idx 2.
- All pixels 0x50 except index 0 = 0xFF with neigh_addr_valid=0xFE -> compare_out=1, equal=0xFE; iterated=0x0F -> pushes 4,5,6,7 only.
- CONN=4 instance: corners 0x90, centre and edges 0x40 -> compare_out=1, equal=0x5A; MODE_MIN=1 with the same window -> compare_out=1, equal=0x5A.
- Backpressure: case 1 with push_ready low for 3 cycles after the first push_valid -> push_idx held at 0 for 4 cycles; total 8 pushes, none lost or duplicated; win_valid ignored (win_ready=0).
- flush asserted during the 3rd push, and separately reset_n low mid-DRAIN -> push_valid=0 and all outputs at reset values; next window is accepted normally and its results are unaffected by the aborted one.
